// File: rtl/issue_scheduler.sv
// Dual-issue dispatch queue between decode and the two execution pipes.
// Accepts up to two instructions per cycle and issues up to two in program order.
module issue_scheduler #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAYLOAD_W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      issue_stall,
  input  logic [1:0]                in_valid,
  input  logic [1:0][PAYLOAD_W-1:0] in_payload,
  input  logic [1:0]                in_reg_we,
  input  logic [1:0][4:0]           in_dest,
  input  logic [1:0][4:0]           in_src1,
  input  logic [1:0][4:0]           in_src2,
  input  logic [1:0][1:0]           in_src_used,
  input  logic [1:0]                in_is_mem,
  input  logic [1:0]                in_is_priv,
  output logic                      pause_req,
  output logic [1:0]                out_valid,
  output logic [1:0][PAYLOAD_W-1:0] out_payload
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 reg_we;
    logic [REG_W-1:0]     dest;
    logic [REG_W-1:0]     src1;
    logic [REG_W-1:0]     src2;
    logic [1:0]           src_used;
    logic                 is_mem;
    logic                 is_priv;
  } entry_t;

  entry_t           q [DEPTH];
  entry_t           in_ent [2];
  entry_t           h0;
  entry_t           h1;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             enq;
  logic             deq;
  logic             raw;
  logic             dual_ok;
  logic [1:0]       n_in;
  logic [1:0]       n_out;

  // Backpressure depends on the registered count only, so it never loops through decode.
  always_comb pause_req = (CNT_W'(DEPTH) - count) < CNT_W'(2);

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      in_ent[s].payload  = in_payload[s];
      in_ent[s].reg_we   = in_reg_we[s];
      in_ent[s].dest     = in_dest[s];
      in_ent[s].src1     = in_src1[s];
      in_ent[s].src2     = in_src2[s];
      in_ent[s].src_used = in_src_used[s];
      in_ent[s].is_mem   = in_is_mem[s];
      in_ent[s].is_priv  = in_is_priv[s];
    end
  end

  // Pair selection on the two oldest entries; h1 is only meaningful when count >= 2.
  always_comb begin
    enq     = !flush && !pause_req;
    n_in    = enq ? (2'(in_valid[0]) + 2'(in_valid[1])) : 2'd0;
    h0      = q[head];
    h1      = q[head + PTR_W'(1)];
    raw     = h0.reg_we && (h0.dest != '0) &&
              ((h1.src_used[0] && (h1.src1 == h0.dest)) ||
               (h1.src_used[1] && (h1.src2 == h0.dest)));
    dual_ok = (count >= CNT_W'(2)) && !h0.is_priv && !h1.is_priv &&
              !(h0.is_mem && h1.is_mem) && !raw;
    deq     = !flush && !issue_stall && (count != '0);
    n_out   = 2'd0;
    if (deq) n_out = dual_ok ? 2'd2 : 2'd1;
  end

  // Entry storage needs no reset: validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      if (in_valid[0]) q[tail]              <= in_ent[0];
      if (in_valid[1]) q[tail + PTR_W'(1)] <= in_ent[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      out_valid   <= '0;
      out_payload <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      out_valid <= '0;
    end else begin
      head  <= head + PTR_W'(n_out);
      tail  <= tail + PTR_W'(n_in);
      count <= count + CNT_W'(n_in) - CNT_W'(n_out);
      if (!issue_stall) begin
        out_valid      <= {n_out == 2'd2, n_out != 2'd0};
        out_payload[0] <= (n_out != 2'd0) ? h0.payload : '0;
        out_payload[1] <= (n_out == 2'd2) ? h1.payload : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (32'(count) + 32'(n_in) <= DEPTH) else $error("issue_scheduler: queue overflow");
      assert (32'(n_out) <= 32'(count)) else $error("issue_scheduler: queue underflow");
    end
  end

endmodule
